addr_reg_stack: RTL and testbench
=================================

ADDR_REG_STACK -- requirements
Module: addr_reg_stack

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, width of the address/data word.
REQ-002 SHALL have parameter DEPTH, default 4, number of return-stack entries; legal range 2..16.
REQ-003 SHALL have parameter CNT_W, default 3, width of the occupancy count; must satisfy 2^CNT_W > DEPTH.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port data_in  input  WORD_SIZE  value for load and call.
REQ-007 SHALL have port op  input  3  command: 000 hold, 001 load, 010 inc, 011 dec, 100 call, 101 ret, 110 clear, 111 hold.
REQ-008 SHALL have port clr_err  input  1  clears the sticky error flags.
REQ-009 SHALL have port data_out  output  WORD_SIZE  current address register value.
REQ-010 SHALL have port count  output  CNT_W  number of valid stack entries.
REQ-011 SHALL have port empty  output  1  high when count == 0.
REQ-012 SHALL have port full  output  1  high when count == DEPTH.
REQ-013 SHALL have port ovf_err  output  1  sticky flag, call attempted while full.
REQ-014 SHALL have port unf_err  output  1  sticky flag, ret attempted while empty.

Function
REQ-015 SHALL register all outputs; a command sampled on clock edge N SHALL be visible on the outputs after edge N, with a latency of one cycle.
REQ-016 SHALL treat hold (000 and 111) as follows: data_out, stack and count unchanged.
REQ-017 SHALL treat load as: data_out <= data_in; stack unchanged.
REQ-018 SHALL treat inc as: data_out <= data_out + 1, modulo 2^WORD_SIZE (FF wraps to 00 for WORD_SIZE=8).
REQ-019 SHALL treat dec as: data_out <= data_out - 1, modulo 2^WORD_SIZE (00 wraps to FF).
REQ-020 SHALL treat call when not full as: push (data_out + 1) mod 2^WORD_SIZE onto the stack, data_out <= data_in, count + 1.
REQ-021 SHALL treat call when full as: no push, data_out unchanged, count unchanged, ovf_err <= 1.
REQ-022 SHALL treat ret when not empty as: data_out <= top entry, pop, count - 1.
REQ-023 SHALL treat ret when empty as: data_out unchanged, count unchanged, unf_err <= 1.
REQ-024 SHALL treat clear as: data_out <= 0, count <= 0, with stack contents don't-care; error flags unchanged.
REQ-025 SHALL operate the stack as LIFO; entries SHALL be written only by call and read only by ret.
REQ-026 SHALL clear both error flags on a clock edge where clr_err=1, unless the same edge sets a flag, in which case setting wins.
REQ-027 SHALL derive empty and full from the count register only, with no combinational path from op.

Reset
REQ-028 SHALL, when rst=1 at a rising edge, set data_out=0, count=0, empty=1, full=0, ovf_err=0 and unf_err=0, overriding op and clr_err.
REQ-029 SHALL NOT require reset of the stack storage; after reset, a ret SHALL flag underflow rather than return a stale entry.
REQ-030 SHALL, when rst is asserted mid-sequence (e.g. with count=2), discard all pending stack state by the next edge.

Verification
REQ-031 SHALL test reset and load: rst=1 for 2 cycles -> data_out=00, empty=1; then load AA -> AA; hold with data_in=55 -> AA retained; load 55 -> 55.
REQ-032 SHALL test wrap: load FF, inc -> 00; dec -> FF.
REQ-033 SHALL test nested call/ret with DEPTH=4: data_out=10; calls to 20,30,40,50 -> count=4, full=1, data_out=50; call 60 -> ovf_err=1, data_out=50; four rets -> 41,31,21,11, empty=1.
REQ-034 SHALL test underflow: from empty, ret -> unf_err=1, data_out unchanged; clr_err -> unf_err=0; ret with clr_err=1 on the same edge -> unf_err=1.
REQ-035 SHALL test reset mid-operation: after two calls (count=2), rst=1 -> count=0, data_out=00; then ret -> unf_err=1.
REQ-036 SHALL test clear: with count=3 and ovf_err=1, op=clear -> data_out=00, count=0, ovf_err=1.

Source files
------------

// File: rtl/addr_reg_stack.sv
// Address register with a small LIFO return stack: load/inc/dec/call/ret/clear
// commands, registered status outputs and sticky overflow/underflow flags.
module addr_reg_stack #(
  parameter int WORD_SIZE = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic [2:0]           op,
  input  logic                 clr_err,
  output logic [WORD_SIZE-1:0] data_out,
  output logic [CNT_W-1:0]     count,
  output logic                 empty,
  output logic                 full,
  output logic                 ovf_err,
  output logic                 unf_err
);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_INC   = 3'b010,
    OP_DEC   = 3'b011,
    OP_CALL  = 3'b100,
    OP_RET   = 3'b101,
    OP_CLEAR = 3'b110,
    OP_HOLD2 = 3'b111
  } op_e;

  localparam int                 IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]   L_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   L_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   L_ZERO  = {CNT_W{1'b0}};
  localparam logic [WORD_SIZE-1:0] L_W_ONE  = WORD_SIZE'(1);
  localparam logic [WORD_SIZE-1:0] L_W_ZERO = {WORD_SIZE{1'b0}};

  logic [WORD_SIZE-1:0] r_data;
  logic [CNT_W-1:0]     r_count;
  logic                 r_empty;
  logic                 r_full;
  logic                 r_ovf;
  logic                 r_unf;
  logic [WORD_SIZE-1:0] r_stack [DEPTH];

  logic [WORD_SIZE-1:0] w_next_data;
  logic [CNT_W-1:0]     w_next_count;
  logic                 w_push;
  logic                 w_set_ovf;
  logic                 w_set_unf;
  logic                 w_is_full;
  logic                 w_is_empty;
  logic [IDX_W-1:0]     w_wr_idx;
  logic [IDX_W-1:0]     w_rd_idx;
  logic [WORD_SIZE-1:0] w_top;
  logic [WORD_SIZE-1:0] w_ret_addr;

  // Occupancy tests are taken from the count register, never from op.
  assign w_is_full  = (r_count == L_DEPTH);
  assign w_is_empty = (r_count == L_ZERO);
  assign w_wr_idx   = IDX_W'(r_count);
  assign w_rd_idx   = IDX_W'(r_count - L_ONE);
  assign w_ret_addr = r_data + L_W_ONE;

  // Top-of-stack read, only meaningful when the stack holds an entry.
  always_comb begin
    w_top = L_W_ZERO;
    if (!w_is_empty) begin
      w_top = r_stack[w_rd_idx];
    end else begin
      w_top = L_W_ZERO;
    end
  end

  // Command decode: next address, next count and error-set strobes.
  always_comb begin
    w_next_data  = r_data;
    w_next_count = r_count;
    w_push       = 1'b0;
    w_set_ovf    = 1'b0;
    w_set_unf    = 1'b0;
    case (op_e'(op))
      OP_LOAD: w_next_data = data_in;
      OP_INC:  w_next_data = r_data + L_W_ONE;
      OP_DEC:  w_next_data = r_data - L_W_ONE;
      OP_CALL: begin
        if (w_is_full) begin
          w_set_ovf = 1'b1;
        end else begin
          w_push       = 1'b1;
          w_next_data  = data_in;
          w_next_count = r_count + L_ONE;
        end
      end
      OP_RET: begin
        if (w_is_empty) begin
          w_set_unf = 1'b1;
        end else begin
          w_next_data  = w_top;
          w_next_count = r_count - L_ONE;
        end
      end
      OP_CLEAR: begin
        w_next_data  = L_W_ZERO;
        w_next_count = L_ZERO;
      end
      OP_HOLD, OP_HOLD2: begin
        w_next_data  = r_data;
        w_next_count = r_count;
      end
      default: begin
        w_next_data  = r_data;
        w_next_count = r_count;
      end
    endcase
  end

  // Address register, count and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= L_W_ZERO;
      r_count <= L_ZERO;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_data  <= w_next_data;
      r_count <= w_next_count;
      r_empty <= (w_next_count == L_ZERO);
      r_full  <= (w_next_count == L_DEPTH);
    end
  end

  // Sticky error flags; a set on the same edge beats clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_set_ovf | (r_ovf & ~clr_err);
      r_unf <= w_set_unf | (r_unf & ~clr_err);
    end
  end

  // Stack storage is deliberately not reset; the count guards stale entries.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_stack[w_wr_idx] <= w_ret_addr;
    end
  end

  assign data_out = r_data;
  assign count    = r_count;
  assign empty    = r_empty;
  assign full     = r_full;
  assign ovf_err  = r_ovf;
  assign unf_err  = r_unf;

endmodule

// File: tb/tb_addr_reg_stack.sv
// Directed-vector bench for addr_reg_stack with hand-computed expectations.
module tb_addr_reg_stack;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic [2:0] op;
  logic       clr_err;
  logic [7:0] data_out;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       ovf_err;
  logic       unf_err;

  int n_vec;
  int n_bad;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, INC = 3'b010, DEC = 3'b011,
                         CALL = 3'b100, RET = 3'b101, CLR = 3'b110, HOLD2 = 3'b111;

  addr_reg_stack #(.WORD_SIZE(8), .DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .op(op), .clr_err(clr_err),
    .data_out(data_out), .count(count), .empty(empty), .full(full),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] o, input logic [7:0] d, input logic c);
    @(negedge clk);
    rst = r; op = o; data_in = d; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [7:0] d, input logic [2:0] c,
                           input logic e, input logic f, input logic ov, input logic un);
    chk({tag, ".data"},  32'(data_out), 32'(d));
    chk({tag, ".count"}, 32'(count),    32'(c));
    chk({tag, ".empty"}, 32'(empty),    32'(e));
    chk({tag, ".full"},  32'(full),     32'(f));
    chk({tag, ".ovf"},   32'(ovf_err),  32'(ov));
    chk({tag, ".unf"},   32'(unf_err),  32'(un));
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b1; op = HOLD; data_in = 8'h00; clr_err = 1'b0;

    // reset and load
    step(1'b1, LOAD, 8'h77, 1'b1);
    step(1'b1, CALL, 8'h66, 1'b0);
    chk_state("reset", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, LOAD, 8'hAA, 1'b0);  chk("load_aa", 32'(data_out), 32'h0000_00AA);
    step(1'b0, HOLD, 8'h55, 1'b0);  chk("hold0",   32'(data_out), 32'h0000_00AA);
    step(1'b0, HOLD2, 8'h55, 1'b0); chk("hold7",   32'(data_out), 32'h0000_00AA);
    step(1'b0, LOAD, 8'h55, 1'b0);  chk("load_55", 32'(data_out), 32'h0000_0055);

    // wrap
    step(1'b0, LOAD, 8'hFF, 1'b0);
    step(1'b0, INC,  8'h00, 1'b0);  chk_state("inc_wrap", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, DEC,  8'h00, 1'b0);  chk("dec_wrap", 32'(data_out), 32'h0000_00FF);

    // nested call/ret
    step(1'b0, LOAD, 8'h10, 1'b0);
    step(1'b0, CALL, 8'h20, 1'b0);  chk_state("call1", 8'h20, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, CALL, 8'h30, 1'b0);  chk_state("call2", 8'h30, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, CALL, 8'h40, 1'b0);  chk_state("call3", 8'h40, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, CALL, 8'h50, 1'b0);  chk_state("call4", 8'h50, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, CALL, 8'h60, 1'b0);  chk_state("call_ovf", 8'h50, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, RET, 8'h00, 1'b0);   chk_state("ret1", 8'h41, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, RET, 8'h00, 1'b0);   chk_state("ret2", 8'h31, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, RET, 8'h00, 1'b0);   chk_state("ret3", 8'h21, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, RET, 8'h00, 1'b0);   chk_state("ret4", 8'h11, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);

    // underflow and sticky clearing
    step(1'b0, RET,  8'h00, 1'b0);  chk_state("unf", 8'h11, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, HOLD, 8'h00, 1'b1);  chk_state("clr_err", 8'h11, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, RET,  8'h00, 1'b1);  chk_state("unf_wins", 8'h11, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, HOLD, 8'h00, 1'b1);  chk("unf_clr2", 32'(unf_err), 32'h0);

    // reset mid-operation
    step(1'b0, CALL, 8'hA0, 1'b0);
    step(1'b0, CALL, 8'hB0, 1'b0);  chk_state("pre_rst", 8'hB0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, CALL, 8'hC0, 1'b0);  chk_state("mid_rst", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, RET,  8'h00, 1'b0);  chk_state("rst_ret", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);

    // clear with count=3 and ovf_err=1
    step(1'b0, HOLD, 8'h00, 1'b1);
    step(1'b0, LOAD, 8'h80, 1'b0);
    step(1'b0, CALL, 8'h01, 1'b0);
    step(1'b0, CALL, 8'h02, 1'b0);
    step(1'b0, CALL, 8'h03, 1'b0);
    step(1'b0, CALL, 8'h04, 1'b0);
    step(1'b0, CALL, 8'h05, 1'b0);  chk_state("fill_ovf", 8'h04, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, RET,  8'h00, 1'b0);  chk_state("pop_to3", 8'h04, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, CLR,  8'hEE, 1'b0);  chk_state("clear", 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, RET,  8'h00, 1'b0);  chk_state("clr_ret", 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
